oled_spi_responder: RTL and testbench

- Synthesizable SSD1306-style display-side model for the Pmod OLED SPI link (CS, MOSI, SCK, D/C).
- Oversamples the serial lines on the system clock and assembles bytes.
- Classifies each byte as command or data and interprets the addressing and control commands the OLED driver emits.
- Writes data bytes into an external GDDRAM port. Used as a loopback bench target and for on-board self-check of the oled controller.

---
 rtl/oled_spi_responder.sv | 217 +++++++++++++++++++++
 tb/tb_oled_spi_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_responder.sv
// SSD1306-style display-side model of the Pmod OLED SPI link: oversamples the serial lines,
// assembles bytes, parses addressing/control commands and writes data bytes to a GDDRAM port.
module oled_spi_responder #(
    parameter int unsigned PAGES   = 4,
    parameter int unsigned COLUMNS = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CS,
    input  logic       MOSI,
    input  logic       SCK,
    input  logic       data_command_cntr,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_is_data,
    output logic       gram_we,
    output logic [8:0] gram_addr,
    output logic [7:0] gram_data,
    output logic [7:0] contrast,
    output logic       display_on,
    output logic       frame_done
);

    localparam logic [6:0] ColLast  = 7'(COLUMNS - 1);
    localparam logic [1:0] PageLast = 2'(PAGES - 1);

    typedef enum logic [1:0] {P_IDLE, P_ARG1, P_ARG2} pstate_e;

    // Synchronizer bit order: {CS, MOSI, SCK, D/C}
    logic [3:0] sync1_q, sync2_q;
    logic       sck_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_out_q, byte_out_d, gram_data_q, gram_data_d, contrast_q, contrast_d;
    logic [7:0] cmd_q, cmd_d;
    logic       byte_valid_q, byte_valid_d, byte_is_data_q, byte_is_data_d;
    logic       gram_we_q, gram_we_d, frame_done_q, frame_done_d;
    logic       display_on_q, display_on_d, mode_page_q, mode_page_d;
    logic [8:0] gram_addr_q, gram_addr_d;
    logic [6:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    pstate_e    state_q, state_d;

    logic       cs_s, mosi_s, sck_s, dc_s, sck_rise, byte_done;
    logic [7:0] new_byte;

    assign cs_s      = sync2_q[3];
    assign mosi_s    = sync2_q[2];
    assign sck_s     = sync2_q[1];
    assign dc_s      = sync2_q[0];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign byte_done = sck_rise & ~cs_s & (bit_cnt_q == 3'd7);
    assign new_byte  = {shift_q[6:0], mosi_s};

    always_comb begin
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        byte_out_d     = byte_out_q;
        byte_valid_d   = 1'b0;
        byte_is_data_d = byte_is_data_q;
        gram_we_d      = 1'b0;
        gram_addr_d    = gram_addr_q;
        gram_data_d    = gram_data_q;
        frame_done_d   = 1'b0;
        contrast_d     = contrast_q;
        display_on_d   = display_on_q;
        mode_page_d    = mode_page_q;
        col_d          = col_q;
        page_d         = page_q;
        col_start_d    = col_start_q;
        col_end_d      = col_end_q;
        page_start_d   = page_start_q;
        page_end_d     = page_end_q;
        state_d        = state_q;
        cmd_d          = cmd_q;

        if (cs_s) begin
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
        end else if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = new_byte;
        end

        if (byte_done) begin
            byte_out_d     = new_byte;
            byte_valid_d   = 1'b1;
            byte_is_data_d = dc_s;
            if (dc_s) begin
                gram_we_d   = 1'b1;
                gram_addr_d = {page_q, col_q};
                gram_data_d = new_byte;
                if (mode_page_q) begin
                    col_d = (col_q == ColLast) ? 7'd0 : col_q + 7'd1;
                end else if (col_q == col_end_q) begin
                    col_d = col_start_q;
                    if (page_q == page_end_q) begin
                        page_d       = page_start_q;
                        frame_done_d = 1'b1;
                    end else begin
                        page_d = page_q + 2'd1;
                    end
                end else begin
                    col_d = col_q + 7'd1;
                end
            end else begin
                unique case (state_q)
                    P_IDLE: begin
                        case (new_byte) inside
                            [8'h00:8'h0F]: col_d[3:0] = new_byte[3:0];
                            [8'h10:8'h1F]: col_d[6:4] = new_byte[2:0];
                            [8'hB0:8'hB7]: page_d = new_byte[1:0];
                            8'hAE:         display_on_d = 1'b0;
                            8'hAF:         display_on_d = 1'b1;
                            8'h20, 8'h21, 8'h22, 8'h81, 8'h8D, 8'hA8,
                            8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                                state_d = P_ARG1;
                                cmd_d   = new_byte;
                            end
                            default: ;
                        endcase
                    end
                    P_ARG1: begin
                        state_d = P_IDLE;
                        case (cmd_q)
                            8'h20: mode_page_d = (new_byte[1:0] == 2'd2);
                            8'h21: begin
                                col_start_d = new_byte[6:0];
                                state_d     = P_ARG2;
                            end
                            8'h22: begin
                                page_start_d = new_byte[1:0];
                                state_d      = P_ARG2;
                            end
                            8'h81: contrast_d = new_byte;
                            default: ;
                        endcase
                    end
                    P_ARG2: begin
                        state_d = P_IDLE;
                        if (cmd_q == 8'h21) begin
                            col_end_d = new_byte[6:0];
                            col_d     = col_start_q;
                        end else begin
                            page_end_d = new_byte[1:0];
                            page_d     = page_start_q;
                        end
                    end
                    default: state_d = P_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q        <= 4'b1000;
            sync2_q        <= 4'b1000;
            sck_prev_q     <= 1'b0;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'h00;
            byte_out_q     <= 8'h00;
            byte_valid_q   <= 1'b0;
            byte_is_data_q <= 1'b0;
            gram_we_q      <= 1'b0;
            gram_addr_q    <= 9'd0;
            gram_data_q    <= 8'h00;
            frame_done_q   <= 1'b0;
            contrast_q     <= 8'h7F;
            display_on_q   <= 1'b0;
            mode_page_q    <= 1'b1;
            col_q          <= 7'd0;
            page_q         <= 2'd0;
            col_start_q    <= 7'd0;
            col_end_q      <= ColLast;
            page_start_q   <= 2'd0;
            page_end_q     <= PageLast;
            state_q        <= P_IDLE;
            cmd_q          <= 8'h00;
        end else begin
            sync1_q        <= {CS, MOSI, SCK, data_command_cntr};
            sync2_q        <= sync1_q;
            sck_prev_q     <= sck_s;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            byte_out_q     <= byte_out_d;
            byte_valid_q   <= byte_valid_d;
            byte_is_data_q <= byte_is_data_d;
            gram_we_q      <= gram_we_d;
            gram_addr_q    <= gram_addr_d;
            gram_data_q    <= gram_data_d;
            frame_done_q   <= frame_done_d;
            contrast_q     <= contrast_d;
            display_on_q   <= display_on_d;
            mode_page_q    <= mode_page_d;
            col_q          <= col_d;
            page_q         <= page_d;
            col_start_q    <= col_start_d;
            col_end_q      <= col_end_d;
            page_start_q   <= page_start_d;
            page_end_q     <= page_end_d;
            state_q        <= state_d;
            cmd_q          <= cmd_d;
        end
    end

    assign byte_out     = byte_out_q;
    assign byte_valid   = byte_valid_q;
    assign byte_is_data = byte_is_data_q;
    assign gram_we      = gram_we_q;
    assign gram_addr    = gram_addr_q;
    assign gram_data    = gram_data_q;
    assign contrast     = contrast_q;
    assign display_on   = display_on_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_oled_spi_responder.sv
// Directed bench for oled_spi_responder: drives SPI bytes and checks strobes, GDDRAM writes
// and control registers against hand-computed values.
module tb_oled_spi_responder;

    logic       clk = 1'b0, rst = 1'b1;
    logic       cs = 1'b1, mosi = 1'b0, sck = 1'b0, dc = 1'b0;
    logic [7:0] byte_out, gram_data, contrast;
    logic [8:0] gram_addr;
    logic       byte_valid, byte_is_data, gram_we, display_on, frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int stray   = 0;

    logic [7:0] q_byte[$];
    logic       q_dc[$];
    logic       q_we[$];
    logic       q_fd[$];
    logic [8:0] q_addr[$];
    logic [7:0] q_gd[$];

    oled_spi_responder dut (
        .clk               (clk),
        .rst               (rst),
        .CS                (cs),
        .MOSI              (mosi),
        .SCK               (sck),
        .data_command_cntr (dc),
        .byte_out          (byte_out),
        .byte_valid        (byte_valid),
        .byte_is_data      (byte_is_data),
        .gram_we           (gram_we),
        .gram_addr         (gram_addr),
        .gram_data         (gram_data),
        .contrast          (contrast),
        .display_on        (display_on),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    // Record every strobe cycle; gram_we/frame_done outside a byte strobe are counted as stray.
    always @(negedge clk) begin
        if (byte_valid) begin
            q_byte.push_back(byte_out);
            q_dc.push_back(byte_is_data);
            q_we.push_back(gram_we);
            q_fd.push_back(frame_done);
            q_addr.push_back(gram_addr);
            q_gd.push_back(gram_data);
        end else if (gram_we || frame_done) begin
            stray++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        q_byte.delete(); q_dc.delete(); q_we.delete();
        q_fd.delete();   q_addr.delete(); q_gd.delete();
    endtask

    // SCK half period 20 ns = 2 clk high / 2 clk low min satisfied (40 ns period)
    task automatic send_byte(input logic [7:0] b, input logic d);
        dc = d;
        cs = 1'b0;
        #20;
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            #20 sck = 1'b1;
            #20 sck = 1'b0;
        end
        #20 cs = 1'b1;
        #60;
    endtask

    initial begin
        logic [7:0] exp_b[$];
        logic       exp_d[$];
        int         bad_addr, bad_we, bad_dat, n_fd, bad_b, bad_d;
        logic [7:0] rb;
        logic       rd;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_byte_out", byte_out, 8'h00);
        check_eq("rst_byte_valid", byte_valid, 1'b0);
        check_eq("rst_gram_addr", gram_addr, 9'd0);
        check_eq("rst_contrast", contrast, 8'h7F);
        check_eq("rst_display_on", display_on, 1'b0);

        // Contrast command
        clear_q();
        send_byte(8'h81, 1'b0);
        send_byte(8'h7A, 1'b0);
        check_eq("contrast_set", contrast, 8'h7A);
        check_eq("contrast_nstrobe", q_byte.size(), 2);
        if (q_byte.size() == 2) begin
            check_eq("contrast_b0", {q_byte[0], 7'd0, q_dc[0], 7'd0, q_we[0]}, {8'h81, 8'h00, 8'h00});
            check_eq("contrast_b1", {q_byte[1], 7'd0, q_dc[1], 7'd0, q_we[1]}, {8'h7A, 8'h00, 8'h00});
        end

        // Horizontal mode, full frame plus one
        send_byte(8'h20, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h21, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h7F, 1'b0);
        send_byte(8'h22, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
        clear_q();
        for (int i = 0; i < 513; i++) send_byte(8'(i * 7 + 3), 1'b1);
        check_eq("horiz_nstrobe", q_addr.size(), 513);
        bad_addr = 0; bad_we = 0; bad_dat = 0; n_fd = 0;
        for (int i = 0; i < q_addr.size() && i < 512; i++) begin
            if (q_addr[i] !== 9'(i)) bad_addr++;
            if (q_we[i] !== 1'b1 || q_dc[i] !== 1'b1) bad_we++;
            if (q_gd[i] !== 8'(i * 7 + 3)) bad_dat++;
            if (q_fd[i]) n_fd++;
        end
        check_eq("horiz_addr_errs", bad_addr, 0);
        check_eq("horiz_we_errs", bad_we, 0);
        check_eq("horiz_data_errs", bad_dat, 0);
        check_eq("horiz_frame_count", n_fd, 1);
        if (q_addr.size() == 513) begin
            check_eq("horiz_frame_on_512", q_fd[511], 1'b1);
            check_eq("horiz_wrap_addr", q_addr[512], 9'd0);
            check_eq("horiz_wrap_nofd", q_fd[512], 1'b0);
        end

        // Page mode addressing and column wrap
        send_byte(8'h20, 1'b0); send_byte(8'h02, 1'b0);
        send_byte(8'hB2, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h13, 1'b0);
        clear_q();
        send_byte(8'hAA, 1'b1);
        check_eq("page_addr", gram_addr, 9'd309);
        check_eq("page_data", gram_data, 8'hAA);
        send_byte(8'hB3, 1'b0); send_byte(8'h1F, 1'b0); send_byte(8'h0F, 1'b0);
        clear_q();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check_eq("page_wrap_n", q_addr.size(), 2);
        if (q_addr.size() == 2) begin
            check_eq("page_addr_511", q_addr[0], 9'd511);
            check_eq("page_addr_384", q_addr[1], 9'd384);
            check_eq("page_wrap_nofd", q_fd[0] | q_fd[1], 1'b0);
        end

        // Partial byte discarded at CS deassertion
        clear_q();
        dc = 1'b0;
        cs = 1'b0;
        #20;
        repeat (5) begin
            mosi = 1'b1;
            #20 sck = 1'b1;
            #20 sck = 1'b0;
        end
        #20 cs = 1'b1;
        #60;
        send_byte(8'hAF, 1'b0);
        check_eq("frag_nstrobe", q_byte.size(), 1);
        if (q_byte.size() == 1) check_eq("frag_byte", q_byte[0], 8'hAF);
        check_eq("frag_display_on", display_on, 1'b1);

        // Reset mid-argument
        send_byte(8'h81, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        clear_q();
        send_byte(8'h55, 1'b0);
        check_eq("rst_arg_contrast", contrast, 8'h7F);
        check_eq("rst_arg_display", display_on, 1'b0);
        send_byte(8'h81, 1'b0);
        send_byte(8'h33, 1'b0);
        check_eq("rst_parser_idle", contrast, 8'h33);

        // Random mixed stream at 40 ns SCK period
        clear_q();
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            rd = 1'($urandom_range(0, 1));
            exp_b.push_back(rb);
            exp_d.push_back(rd);
            send_byte(rb, rd);
        end
        check_eq("rand_nstrobe", q_byte.size(), 40);
        bad_b = 0; bad_d = 0;
        for (int i = 0; i < q_byte.size() && i < 40; i++) begin
            if (q_byte[i] !== exp_b[i]) bad_b++;
            if (q_dc[i] !== exp_d[i] || q_we[i] !== exp_d[i]) bad_d++;
        end
        check_eq("rand_byte_errs", bad_b, 0);
        check_eq("rand_dc_errs", bad_d, 0);

        check_eq("stray_strobes", stray, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
